pixel_pack_writer: RTL and testbench
====================================

PIXEL_PACK_WRITER -- requirements
Module: pixel_pack_writer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDR_WIDTH_PS, 32, byte address width of the intermediate-results BRAM port
  DATA_WIDTH_PS, 32, BRAM word width (4 pixels)
  PIXEL_WIDTH, 8, pixel width
  NUM_PIXELS, 784, pixels per image
  NUM_IMAGES, 8, images per batch
  BASE_ADDR, 32'h0000_0000, byte address of the first written word
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all logic rising-edge
  reset  in  1  asynchronous, active-low reset
  start  in  1  one-cycle pulse that arms a batch
  pixel  in  PIXEL_WIDTH  augmented pixel from the augmentation stage
  pixel_valid  in  1  pixel qualifier, one pixel per asserted cycle
  bram_addr  out  ADDR_WIDTH_PS  byte address of the word being written
  bram_data  out  DATA_WIDTH_PS  packed word
  bram_w_enable  out  4  per-byte write enable
  busy  out  1  high from the accepted start until batch_done
  batch_done  out  1  one-cycle pulse after the last word of the batch is written
  overflow  out  1  sticky flag: pixel_valid was seen while not armed

Function
REQ-003 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE on acceptance of pixel NUM_PIXELS-1 of image NUM_IMAGES-1; DONE->IDLE unconditionally after 1 cycle.
REQ-004 start in RUN or DONE SHALL be ignored, with no counter restart.
REQ-005 In RUN, each pixel_valid cycle SHALL place the pixel in byte lane byte_idx (lane 0 = bits 7:0, little-endian) and increment byte_idx modulo 4.
REQ-006 A write SHALL be issued when lane 3 is filled or the image's last pixel is accepted, with bram_w_enable set to the filled lanes only (4'hF for a full word; 4'b0001/0011/0111 for a partial final word).
REQ-007 Write outputs SHALL be registered: bram_addr, bram_data and bram_w_enable are valid in the cycle after the triggering pixel, and bram_w_enable is 4'h0 in every other cycle.
REQ-008 Unfilled lanes of bram_data SHALL be driven as 0.
REQ-009 Every image SHALL start in lane 0 of a new word; the word address SHALL advance by 4 bytes per write and never reset within a batch.
REQ-010 Words per image SHALL be ceil(NUM_PIXELS/4), i.e. 196 at default; the last batch word SHALL be at BASE_ADDR+4*(NUM_IMAGES*196-1), i.e. 32'h0000_187C at default.
REQ-011 pixel_valid on consecutive cycles SHALL be sustained with no stall, and gaps of any length SHALL be tolerated.
REQ-012 batch_done SHALL pulse in the DONE cycle, which is the cycle the final write is presented, and busy SHALL fall in that same cycle.
REQ-013 pixel_valid in IDLE or DONE SHALL be dropped and SHALL set overflow, which is cleared only by reset or an accepted start.
REQ-014 Pixel, image and word counters SHALL be sized with $clog2 of their terminal values, and no counter SHALL wrap inside a batch.

Reset
REQ-015 While reset=0, the block SHALL be in IDLE with every counter, bram_addr=BASE_ADDR, bram_data=0, bram_w_enable=0, busy=0, batch_done=0 and overflow=0.
REQ-016 Reset asserted mid-batch SHALL abort the batch immediately, with no partial-word write after release.

Structure
REQ-017 The state enum and the per-image word-count constant SHALL be placed in the shared augmentation package.
REQ-018 Lane packing and enable generation SHALL be a sub-module named byte_lane_packer; the FSM, counters and address logic SHALL stay in pixel_pack_writer.

Verification
REQ-019 start, then 4 pixels 8'h11,22,33,44 back-to-back -> one cycle later addr 32'h0, data 32'h4433_2211, w_enable 4'hF.
REQ-020 Full default batch of 6272 pixels streamed without gaps -> exactly 1568 writes, last at 32'h187C, batch_done pulses once and busy falls in the same cycle.
REQ-021 NUM_PIXELS=6, NUM_IMAGES=2, pixels 1..12 -> writes (0x0,0x04030201,F), (0x4,0x00000605,3), (0x8,0x0A090807,F), (0xC,0x00000C0B,3).
REQ-022 Random pixel_valid gaps (30% duty) -> write stream identical to the gapless case.
REQ-023 pixel_valid before start -> overflow=1 and no write; a following start clears overflow.
REQ-024 reset low after 10 pixels of a batch, then released, then a new start -> first write at BASE_ADDR containing only the new pixels.

Source files
------------

// File: rtl/pixel_pack_writer_pkg.sv
// Shared augmentation package: writer FSM states, lane geometry and sizing helpers.
package pixel_pack_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned LANES              = 4;
    localparam int unsigned DEFAULT_NUM_PIXELS = 784;

    // Each image is padded up to whole words.
    function automatic int unsigned words_per_image(input int unsigned num_pixels);
        return (num_pixels + LANES - 1) / LANES;
    endfunction

    localparam int unsigned WORDS_PER_IMAGE = words_per_image(DEFAULT_NUM_PIXELS);

    // Counter width for a terminal value, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

    // Write enable covering lanes 0..last_lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] last_lane);
        logic [3:0] mask;
        case (last_lane)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// Packs pixels little-endian into BRAM words and issues registered byte-enabled writes.
module byte_lane_packer
    import pixel_pack_writer_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [PIXEL_WIDTH-1:0] pixel,
    input  logic                   pixel_valid,
    input  logic                   last,
    output logic [DATA_WIDTH-1:0]  bram_data,
    output logic [3:0]             bram_w_enable,
    output logic                   write_c
);

    logic [DATA_WIDTH-1:0] acc_q;
    logic [1:0]            idx_q;
    logic [DATA_WIDTH-1:0] merged_c;

    // Accumulator only ever holds filled lanes, so unfilled lanes stay zero.
    always_comb begin
        merged_c = acc_q | (DATA_WIDTH'(pixel) << (int'(idx_q) * PIXEL_WIDTH));
        write_c  = pixel_valid && ((idx_q == 2'd3) || last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q         <= '0;
            idx_q         <= '0;
            bram_data     <= '0;
            bram_w_enable <= '0;
        end else begin
            bram_w_enable <= '0;
            if (clear) begin
                acc_q <= '0;
                idx_q <= '0;
            end else if (pixel_valid) begin
                if (write_c) begin
                    bram_data     <= merged_c;
                    bram_w_enable <= lane_mask(idx_q);
                    acc_q         <= '0;
                    idx_q         <= '0;
                end else begin
                    acc_q <= merged_c;
                    idx_q <= idx_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_pack_writer.sv
// Writes a batch of augmented images into the intermediate-results BRAM, four pixels per word.
module pixel_pack_writer
    import pixel_pack_writer_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH_PS = 32,
    parameter int unsigned              DATA_WIDTH_PS = 32,
    parameter int unsigned              PIXEL_WIDTH   = 8,
    parameter int unsigned              NUM_PIXELS    = 784,
    parameter int unsigned              NUM_IMAGES    = 8,
    parameter logic [ADDR_WIDTH_PS-1:0] BASE_ADDR     = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PIXEL_WIDTH-1:0]   pixel,
    input  logic                     pixel_valid,
    output logic [ADDR_WIDTH_PS-1:0] bram_addr,
    output logic [DATA_WIDTH_PS-1:0] bram_data,
    output logic [3:0]               bram_w_enable,
    output logic                     busy,
    output logic                     batch_done,
    output logic                     overflow
);

    localparam int unsigned WPI         = words_per_image(NUM_PIXELS);
    localparam int unsigned TOTAL_WORDS = NUM_IMAGES * WPI;
    localparam int unsigned PIX_W       = cnt_width(NUM_PIXELS);
    localparam int unsigned IMG_W       = cnt_width(NUM_IMAGES);
    localparam int unsigned WORD_W      = cnt_width(TOTAL_WORDS + 1);

    state_e            state_q, state_d;
    logic [PIX_W-1:0]  pix_cnt_q;
    logic [IMG_W-1:0]  img_cnt_q;
    logic [WORD_W-1:0] word_cnt_q;

    logic start_ok_c, accept_c, last_pix_c, last_img_c, write_c;
    logic busy_d, done_d, overflow_d;

    assign last_pix_c = (pix_cnt_q == PIX_W'(NUM_PIXELS - 1));
    assign last_img_c = (img_cnt_q == IMG_W'(NUM_IMAGES - 1));

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        start_ok_c = 1'b0;
        accept_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    start_ok_c = 1'b1;
                end
            end
            RUN: begin
                accept_c = pixel_valid;
                if (pixel_valid && last_pix_c && last_img_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d == RUN);
        done_d     = (state_d == DONE);
        overflow_d = overflow;
        if (start_ok_c) begin
            overflow_d = 1'b0;
        end
        if (pixel_valid && (state_q != RUN)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            batch_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= busy_d;
            batch_done <= done_d;
            overflow   <= overflow_d;
        end
    end

    // Pixel/image position within the batch; the image counter returns to zero on the last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_q <= '0;
            img_cnt_q <= '0;
        end else if (start_ok_c) begin
            pix_cnt_q <= '0;
            img_cnt_q <= '0;
        end else if (accept_c) begin
            if (last_pix_c) begin
                pix_cnt_q <= '0;
                img_cnt_q <= last_img_c ? '0 : img_cnt_q + 1'b1;
            end else begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end
        end
    end

    // Word address advances by one word per write for the whole batch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt_q <= '0;
            bram_addr  <= BASE_ADDR;
        end else if (start_ok_c) begin
            word_cnt_q <= '0;
        end else if (write_c) begin
            bram_addr  <= BASE_ADDR + (ADDR_WIDTH_PS'(word_cnt_q) << 2);
            word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    byte_lane_packer #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH_PS)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_ok_c),
        .pixel         (pixel),
        .pixel_valid   (accept_c),
        .last          (last_pix_c),
        .bram_data     (bram_data),
        .bram_w_enable (bram_w_enable),
        .write_c       (write_c)
    );

endmodule

// File: tb/tb_pixel_pack_writer.sv
// Directed bench for pixel_pack_writer: default batch instance plus a small 6x2 instance.
module tb_pixel_pack_writer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  en;
    } wr_t;

    typedef struct {
        logic [7:0]  pix;
        logic [3:0]  en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_start, a_valid;
    logic [7:0]  a_pix;
    logic [31:0] a_addr, a_data;
    logic [3:0]  a_en;
    logic        a_busy, a_done, a_ovf;

    logic        b_start, b_valid;
    logic [7:0]  b_pix;
    logic [31:0] b_addr, b_data;
    logic [3:0]  b_en;
    logic        b_busy, b_done, b_ovf;

    pixel_pack_writer dut_a (
        .clk(clk), .reset(reset), .start(a_start), .pixel(a_pix), .pixel_valid(a_valid),
        .bram_addr(a_addr), .bram_data(a_data), .bram_w_enable(a_en),
        .busy(a_busy), .batch_done(a_done), .overflow(a_ovf)
    );

    pixel_pack_writer #(.NUM_PIXELS(6), .NUM_IMAGES(2)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .pixel(b_pix), .pixel_valid(b_valid),
        .bram_addr(b_addr), .bram_data(b_data), .bram_w_enable(b_en),
        .busy(b_busy), .batch_done(b_done), .overflow(b_ovf)
    );

    int total  = 0;
    int passed = 0;

    wr_t wq[$];
    int  done_cnt     = 0;
    int  busy_at_done = 0;

    // Write/done monitor for the default instance.
    always @(negedge clk) begin
        if (a_en != 4'h0) wq.push_back({a_addr, a_data, a_en});
        if (a_done) begin
            done_cnt++;
            if (a_busy) busy_at_done++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] pix_of(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Reference write for word k of the default 784x8 batch.
    function automatic wr_t exp_word(input int k);
        wr_t w;
        int  img, wi, n;
        img = k / 196;
        wi  = k % 196;
        n   = (784 - 4 * wi) < 4 ? (784 - 4 * wi) : 4;
        w.addr = 32'(4 * k);
        w.data = '0;
        for (int l = 0; l < n; l++) w.data = w.data | (32'(pix_of(img * 784 + 4 * wi + l)) << (8 * l));
        w.en = 4'((1 << n) - 1);
        return w;
    endfunction

    task automatic run_batch(input bit gaps, input string tag);
        int i, cycles, errs, first_bad, d0;
        wq.delete();
        d0 = done_cnt;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        i = 0;
        cycles = 0;
        while (i < 6272 && cycles < 40000) begin
            a_valid = gaps ? ($urandom_range(0, 99) < 30) : 1'b1;
            a_pix   = pix_of(i);
            a_start = (!gaps && i == 1000);
            @(negedge clk);
            if (a_valid) i++;
            cycles++;
        end
        a_valid = 1'b0;
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_pixels_sent"}, 32'(i), 32'd6272);
        check({tag, "_write_count"}, 32'(wq.size()), 32'd1568);
        errs = 0;
        first_bad = -1;
        for (int k = 0; k < wq.size() && k < 1568; k++) begin
            if (wq[k] !== exp_word(k)) begin
                errs++;
                if (first_bad < 0) first_bad = k;
            end
        end
        check($sformatf("%s_stream_errs_first_word_%0d", tag, first_bad), 32'(errs), 32'd0);
        if (wq.size() > 0) check({tag, "_last_addr"}, wq[wq.size()-1].addr, 32'h0000_187C);
        else check({tag, "_last_addr"}, 32'hFFFF_FFFF, 32'h0000_187C);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_low_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, "_busy_after"}, 32'(a_busy), 32'd0);
    endtask

    vec_t avec[4];
    vec_t bvec[12];

    initial begin
        avec[0] = '{8'h11, 4'h0, 32'h0, 32'h0, 1'b0};
        avec[1] = '{8'h22, 4'h0, 32'h0, 32'h0, 1'b0};
        avec[2] = '{8'h33, 4'h0, 32'h0, 32'h0, 1'b0};
        avec[3] = '{8'h44, 4'hF, 32'h0, 32'h4433_2211, 1'b0};
        for (int i = 0; i < 12; i++) bvec[i] = '{8'(i + 1), 4'h0, 32'h0, 32'h0, 1'b0};
        bvec[3].en  = 4'hF; bvec[3].addr  = 32'h0; bvec[3].data  = 32'h0403_0201;
        bvec[5].en  = 4'h3; bvec[5].addr  = 32'h4; bvec[5].data  = 32'h0000_0605;
        bvec[9].en  = 4'hF; bvec[9].addr  = 32'h8; bvec[9].data  = 32'h0A09_0807;
        bvec[11].en = 4'h3; bvec[11].addr = 32'hC; bvec[11].data = 32'h0000_0C0B;
        bvec[11].done = 1'b1;

        reset = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_pix = '0;
        b_start = 1'b0; b_valid = 1'b0; b_pix = '0;
        repeat (3) @(negedge clk);
        check("rst_addr", a_addr, 32'h0);
        check("rst_data", a_data, 32'h0);
        check("rst_en", 32'(a_en), 32'h0);
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_done", 32'(a_done), 32'h0);
        check("rst_ovf", 32'(a_ovf), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Pixel while idle: dropped and flagged; a start clears the flag.
        a_valid = 1'b1; a_pix = 8'h55;
        @(negedge clk);
        a_valid = 1'b0;
        check("ovf_set", 32'(a_ovf), 32'h1);
        repeat (3) @(negedge clk);
        check("ovf_no_write", 32'(wq.size()), 32'h0);
        check("ovf_sticky", 32'(a_ovf), 32'h1);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("ovf_cleared", 32'(a_ovf), 32'h0);
        check("busy_after_start", 32'(a_busy), 32'h1);

        // First word timing and packing.
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_pix = avec[i].pix;
            @(negedge clk);
            check($sformatf("a_vec%0d_en", i), 32'(a_en), 32'(avec[i].en));
            if (avec[i].en != 4'h0) begin
                check($sformatf("a_vec%0d_addr", i), a_addr, avec[i].addr);
                check($sformatf("a_vec%0d_data", i), a_data, avec[i].data);
            end
        end
        for (int i = 0; i < 6; i++) begin
            a_pix = 8'(i + 1);
            @(negedge clk);
        end
        a_valid = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();

        // Reset mid-batch with two pixels pending in the packer.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_write", 32'(wq.size()), 32'h0);
        check("abort_busy", 32'(a_busy), 32'h0);
        check("abort_addr", a_addr, 32'h0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_pix = 8'(8'hAA + 8'(i * 17));
            @(negedge clk);
        end
        a_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("restart_count", 32'(wq.size()), 32'h1);
        if (wq.size() > 0) begin
            check("restart_addr", wq[0].addr, 32'h0);
            check("restart_data", wq[0].data, 32'hDDCC_BBAA);
            check("restart_en", 32'(wq[0].en), 32'hF);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_batch(1'b0, "gapless");
        run_batch(1'b1, "gapped");

        // Small instance: partial final words and image alignment.
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b_valid = 1'b1; b_pix = bvec[i].pix;
            @(negedge clk);
            check($sformatf("b_vec%0d_en", i), 32'(b_en), 32'(bvec[i].en));
            check($sformatf("b_vec%0d_done", i), 32'(b_done), 32'(bvec[i].done));
            if (bvec[i].en != 4'h0) begin
                check($sformatf("b_vec%0d_addr", i), b_addr, bvec[i].addr);
                check($sformatf("b_vec%0d_data", i), b_data, bvec[i].data);
            end
        end
        b_valid = 1'b0;
        check("b_busy_at_done", 32'(b_busy), 32'h0);
        @(negedge clk);
        check("b_done_one_cycle", 32'(b_done), 32'h0);
        check("b_en_idle", 32'(b_en), 32'h0);
        check("b_ovf", 32'(b_ovf), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
